// File: rtl/riscv_privileged_pkg.sv
// Shared privileged-architecture types for the trap sequencer: privilege levels,
// sequencer states, exception codes and the fixed interrupt priority order.
package riscv_privileged_pkg;

  typedef enum logic [1:0] {
    USER       = 2'b00,
    SUPERVISOR = 2'b01,
    MACHINE    = 2'b11
  } privilege_level_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    TRAP_WAIT = 2'b01,
    RET_WAIT  = 2'b10
  } trap_state_t;

  typedef enum logic [5:0] {
    INSTR_ADDR_MISALIGNED = 6'd0,
    INSTR_ACCESS_FAULT    = 6'd1,
    ILLEGAL_INSTRUCTION   = 6'd2,
    BREAKPOINT            = 6'd3,
    LOAD_ADDR_MISALIGNED  = 6'd4,
    LOAD_ACCESS_FAULT     = 6'd5,
    STORE_ADDR_MISALIGNED = 6'd6,
    STORE_ACCESS_FAULT    = 6'd7,
    ECALL_U               = 6'd8,
    ECALL_S               = 6'd9,
    ECALL_M               = 6'd11
  } synchronous_exception_code_t;

  localparam int unsigned NUM_IRQ  = 14;
  localparam int unsigned NUM_PRIO = 7;

  // Element 0 is the highest priority: MEI, MSI, MTI, SEI, SSI, STI, LCOF.
  localparam logic [NUM_PRIO-1:0][3:0] IRQ_PRIO_ORDER = {
    4'd13, 4'd5, 4'd1, 4'd9, 4'd7, 4'd3, 4'd11
  };

  function automatic logic [63:0] trap_base(input logic [63:0] mtvec);
    return {mtvec[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/trap_irq_arbiter.sv
// Combinational fixed-priority pick of the highest-priority pending interrupt.
module trap_irq_arbiter
  import riscv_privileged_pkg::*;
(
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               valid_o,
  output logic [3:0]         code_o
);

  // Walk lowest to highest priority so the highest pending source wins.
  always_comb begin
    valid_o = 1'b0;
    code_o  = 4'd0;
    for (int i = NUM_PRIO - 1; i >= 0; i--) begin
      if (irq_i[IRQ_PRIO_ORDER[i]]) begin
        valid_o = 1'b1;
        code_o  = IRQ_PRIO_ORDER[i];
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer with a fetch-redirect handshake.
// Define TRAP_SEQUENCER_VECTORED_EN to enable vectored interrupt targets (mtvec mode 1).
module trap_sequencer
  import riscv_privileged_pkg::*;
#(
  parameter privilege_level_t RESET_PRIV   = MACHINE,
  parameter logic [63:0]      RESET_VECTOR = 64'h0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         exc_valid_i,
  input  logic [5:0]   exc_code_i,
  input  logic [63:0]  exc_pc_i,
  input  logic [63:0]  exc_tval_i,
  input  logic         mret_i,
  input  logic [13:0]  irq_i,
  input  logic [63:0]  mtvec_i,
  output logic         redirect_valid_o,
  input  logic         redirect_ready_i,
  output logic [63:0]  redirect_pc_o,
  output logic [63:0]  mepc_o,
  output logic [63:0]  mcause_o,
  output logic [63:0]  mtval_o,
  output logic         mstatus_mie_o,
  output logic         mstatus_mpie_o,
  output logic [1:0]   mstatus_mpp_o,
  output logic [1:0]   priv_o,
  output logic         busy_o
);

  trap_state_t      state_q;
  logic             redirect_valid_q;
  logic [63:0]      redirect_pc_q;
  logic [63:0]      mepc_q, mcause_q, mtval_q;
  logic             mie_q, mpie_q;
  privilege_level_t mpp_q, priv_q;

  logic        irq_valid;
  logic [3:0]  irq_code;
  logic        irq_take, exc_take, mret_take, mret_legal;
  logic        trap_take, ret_take;
  logic [63:0] trap_cause, trap_tval, trap_target;
  logic        unused_bits;

  trap_irq_arbiter u_irq_arbiter (
    .irq_i   (irq_i),
    .valid_o (irq_valid),
    .code_o  (irq_code)
  );

  assign exc_take   = exc_valid_i;
  assign irq_take   = !exc_valid_i && irq_valid && (priv_q != MACHINE || mie_q);
  assign mret_take  = !exc_valid_i && !irq_take && mret_i;
  assign mret_legal = (priv_q == MACHINE);
  // An MRET below machine mode turns into an illegal-instruction trap.
  assign trap_take  = exc_take || irq_take || (mret_take && !mret_legal);
  assign ret_take   = mret_take && mret_legal;

  assign unused_bits = ^{exc_pc_i[0], mtvec_i[1:0]};

  always_comb begin
    trap_cause = {58'd0, ILLEGAL_INSTRUCTION};
    trap_tval  = 64'd0;
    if (exc_take) begin
      trap_cause = {58'd0, exc_code_i};
      trap_tval  = exc_tval_i;
    end else if (irq_take) begin
      trap_cause = {1'b1, 59'd0, irq_code};
    end
  end

  always_comb begin
    trap_target = trap_base(mtvec_i);
`ifdef TRAP_SEQUENCER_VECTORED_EN
    if (irq_take && mtvec_i[1:0] == 2'b01) begin
      trap_target = trap_base(mtvec_i) + {58'd0, irq_code, 2'b00};
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 64'd0;
      mepc_q           <= RESET_VECTOR;
      mcause_q         <= 64'd0;
      mtval_q          <= 64'd0;
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mpp_q            <= MACHINE;
      priv_q           <= RESET_PRIV;
    end else begin
      case (state_q)
        IDLE: begin
          if (trap_take) begin
            state_q          <= TRAP_WAIT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= trap_target;
            mepc_q           <= {exc_pc_i[63:1], 1'b0};
            mcause_q         <= trap_cause;
            mtval_q          <= trap_tval;
            mpie_q           <= mie_q;
            mie_q            <= 1'b0;
            mpp_q            <= priv_q;
            priv_q           <= MACHINE;
          end else if (ret_take) begin
            state_q          <= RET_WAIT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= mepc_q;
            priv_q           <= mpp_q;
            mie_q            <= mpie_q;
            mpie_q           <= 1'b1;
            mpp_q            <= USER;
          end
        end
        TRAP_WAIT, RET_WAIT: begin
          if (redirect_ready_i) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= IDLE;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign mepc_o           = mepc_q;
  assign mcause_o         = mcause_q;
  assign mtval_o          = mtval_q;
  assign mstatus_mie_o    = mie_q;
  assign mstatus_mpie_o   = mpie_q;
  assign mstatus_mpp_o    = mpp_q;
  assign priv_o           = priv_q;
  assign busy_o           = (state_q != IDLE);

endmodule
